// File: rtl/fdc_pkg.sv
// Shared opcodes, special words and state encoding for the fetch/decode boundary stage.
package fdc_pkg;

  localparam logic [2:0] OP_JMP    = 3'b110;
  localparam logic [2:0] OP_BRZ    = 3'b101;
  localparam logic [8:0] NOP_WORD  = 9'h000;
  localparam logic [8:0] HALT_WORD = 9'h1FF;

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} fdc_state_t;

endpackage

// File: rtl/fetch_decode_ctrl_lut.sv
// Jump-target table: register array with one synchronous write port and one
// combinational read port; cleared asynchronously by the active-low reset.
module jump_lut #(
  parameter int unsigned LUT_N = 32,
  parameter int unsigned IW    = 9,
  localparam int unsigned AW   = $clog2(LUT_N)
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          We,
  input  logic [AW-1:0] Wr_Addr,
  input  logic [IW-1:0] Wr_Data,
  input  logic [AW-1:0] Rd_Addr,
  output logic [IW-1:0] Rd_Data
);

  logic [IW-1:0] mem [LUT_N];

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < LUT_N; i++) mem[i] <= '0;
    end else if (We) begin
      mem[Wr_Addr] <= Wr_Data;
    end
  end

  // Read is taken from the registers, so a same-cycle write shows the old value.
  assign Rd_Data = mem[Rd_Addr];

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode boundary: registers the fetched word into IR, resolves jumps,
// branches and HALT, and squashes the wrong-path word behind a taken jump.
module fetch_decode_ctrl
  import fdc_pkg::*;
#(
  parameter int unsigned IW    = 9,
  parameter int unsigned LUT_N = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [IW-1:0]    Instr_In,
  input  logic             Cond_Flag,
  input  logic             Stall,
  input  logic             Lut_We,
  input  logic [4:0]       Lut_Addr,
  input  logic [IW-1:0]    Lut_Data,
  output logic [IW-1:0]    IR_Out,
  output logic             IR_Valid,
  output logic             Abs_Jump,
  output logic [IW-1:0]    Offset,
  output logic             Halt,
  output logic             Done,
  output logic [CNT_W-1:0] Jump_Cnt
);

  fdc_state_t state;
  logic       is_halt, is_jmp, is_brz, taken, lut_we;

  always_comb begin
    is_halt  = IR_Valid && (IR_Out == HALT_WORD);
    is_jmp   = IR_Valid && (IR_Out[IW-1 -: 3] == OP_JMP);
    is_brz   = IR_Valid && (IR_Out[IW-1 -: 3] == OP_BRZ);
    taken    = (state == RUN) && !Stall && (is_jmp || (is_brz && Cond_Flag));
    Abs_Jump = Reset && taken;
    Halt     = 1'b0;
    unique case (state)
      RUN:     Halt = Stall || is_halt;
      FLUSH:   Halt = Stall;
      HALTED:  Halt = 1'b1;
      default: Halt = 1'b0;
    endcase
    // Fetch controls are forced quiet while reset is asserted.
    Halt   = Halt && Reset;
    lut_we = Lut_We && ((state == HALTED) || !IR_Valid);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= RUN;
      IR_Out   <= NOP_WORD;
      IR_Valid <= 1'b0;
      Done     <= 1'b0;
      Jump_Cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!Stall) begin
            if (taken) begin
              IR_Out   <= NOP_WORD;
              IR_Valid <= 1'b0;
              state    <= FLUSH;
              if (Jump_Cnt != '1) Jump_Cnt <= Jump_Cnt + 1'b1;
            end else if (is_halt) begin
              IR_Valid <= 1'b0;
              Done     <= 1'b1;
              state    <= HALTED;
            end else begin
              IR_Out   <= Instr_In;
              IR_Valid <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!Stall) begin
            IR_Out   <= Instr_In;
            IR_Valid <= 1'b1;
            state    <= RUN;
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

  jump_lut #(
    .LUT_N (LUT_N),
    .IW    (IW)
  ) u_lut (
    .CLK     (CLK),
    .Reset   (Reset),
    .We      (lut_we),
    .Wr_Addr (Lut_Addr),
    .Wr_Data (Lut_Data),
    .Rd_Addr (IR_Out[4:0]),
    .Rd_Data (Offset)
  );

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: a behavioural fetch stage plus instruction memory
// drive the DUT; a cycle-level model of the stage rules predicts every output.
module tb_fetch_decode_ctrl;

  localparam int IW    = 9;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             Reset;
  logic [IW-1:0]    Instr_In;
  logic             Cond_Flag, Stall, Lut_We;
  logic [4:0]       Lut_Addr;
  logic [IW-1:0]    Lut_Data;
  logic [IW-1:0]    IR_Out, Offset;
  logic             IR_Valid, Abs_Jump, Halt, Done;
  logic [CNT_W-1:0] Jump_Cnt;

  fetch_decode_ctrl #(.IW(IW), .LUT_N(32), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .Instr_In(Instr_In), .Cond_Flag(Cond_Flag),
    .Stall(Stall), .Lut_We(Lut_We), .Lut_Addr(Lut_Addr), .Lut_Data(Lut_Data),
    .IR_Out(IR_Out), .IR_Valid(IR_Valid), .Abs_Jump(Abs_Jump), .Offset(Offset),
    .Halt(Halt), .Done(Done), .Jump_Cnt(Jump_Cnt)
  );

  always #5 CLK = ~CLK;

  int tests  = 0;
  int failed = 0;

  // Environment: instruction memory and the fetch stage's PC.
  logic [8:0] imem [512];
  logic [8:0] m_pc;

  // Reference model of the stage (m_mode: 0 running, 1 flushing, 2 halted).
  int         m_mode;
  logic [8:0] m_ir;
  logic       m_valid, m_done;
  int         m_cnt;
  logic [8:0] m_lut [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_ir = 9'h000; m_valid = 1'b0; m_done = 1'b0; m_cnt = 0; m_pc = 9'h000;
    for (int i = 0; i < 32; i++) m_lut[i] = 9'h000;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".ir"},    IR_Out,   0);
    chk({tag, ".valid"}, IR_Valid, 0);
    chk({tag, ".cnt"},   Jump_Cnt, 0);
    chk({tag, ".done"},  Done,     0);
    chk({tag, ".abs"},   Abs_Jump, 0);
    chk({tag, ".halt"},  Halt,     0);
    chk({tag, ".off"},   Offset,   0);
  endtask

  // Called at a falling edge; holds reset for one rising edge with noisy inputs.
  task automatic apply_reset();
    Reset = 1'b0; Stall = 1'b1; Cond_Flag = 1'b1; Lut_We = 1'b1;
    Lut_Addr = 5'd0; Lut_Data = 9'h1AB; Instr_In = 9'h183;
    #1 check_reset_values("rst");
    @(posedge CLK); #1 check_reset_values("rst_hold");
    @(negedge CLK);
    Reset = 1'b1; Lut_We = 1'b0;
    m_reset();
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input logic st, input logic cd, input logic we,
                      input logic [4:0] a, input logic [8:0] d);
    logic       e_abs, e_halt, jmp, brz, hlt;
    logic [8:0] word, tgt;
    Stall = st; Cond_Flag = cd; Lut_We = we; Lut_Addr = a; Lut_Data = d;
    word = imem[m_pc];
    Instr_In = word;
    tgt = m_lut[m_ir[4:0]];
    hlt = m_valid && (m_ir == 9'h1FF);
    jmp = m_valid && (m_ir[8:6] == 3'b110);
    brz = m_valid && (m_ir[8:6] == 3'b101);
    e_abs = 1'b0; e_halt = 1'b0;
    if (m_mode == 2)      e_halt = 1'b1;
    else if (m_mode == 1) e_halt = st;
    else if (st)          e_halt = 1'b1;
    else if (hlt)         e_halt = 1'b1;
    else if (jmp || (brz && cd)) e_abs = 1'b1;
    #1;
    chk("ir",     IR_Out,   m_ir);
    chk("valid",  IR_Valid, m_valid);
    chk("abs",    Abs_Jump, e_abs);
    chk("halt",   Halt,     e_halt);
    chk("offset", Offset,   tgt);
    chk("done",   Done,     m_done);
    chk("cnt",    Jump_Cnt, m_cnt);
    @(posedge CLK);
    if (we && (m_mode == 2 || !m_valid)) m_lut[a] = d;
    if (m_mode == 1) begin
      if (!st) begin m_ir = word; m_valid = 1'b1; m_mode = 0; end
    end else if (m_mode == 0 && !st) begin
      if (e_abs) begin
        m_ir = 9'h000; m_valid = 1'b0; m_mode = 1;
        if (m_cnt < CMAX) m_cnt++;
      end else if (hlt) begin
        m_valid = 1'b0; m_done = 1'b1; m_mode = 2;
      end else begin
        m_ir = word; m_valid = 1'b1;
      end
    end
    if (!e_halt) m_pc = e_abs ? tgt : m_pc + 9'd1;
    @(negedge CLK);
  endtask

  function automatic logic [8:0] rand_word();
    int unsigned r;
    logic [8:0]  w;
    r = $urandom_range(99);
    w = 9'($urandom);
    if (r < 15)      w[8:6] = 3'b110;
    else if (r < 30) w[8:6] = 3'b101;
    else if (r < 32) w = 9'h1FF;
    else if (w[8:6] == 3'b110 || w[8:6] == 3'b101 || w == 9'h1FF) w[8:6] = 3'b001;
    return w;
  endfunction

  logic       dir_st [20];
  logic       dir_cd [20];
  logic       mid_reset_done;

  initial begin
    Reset = 1'b0; Stall = 1'b0; Cond_Flag = 1'b0; Lut_We = 1'b0;
    Lut_Addr = '0; Lut_Data = '0; Instr_In = '0;
    for (int i = 0; i < 512; i++) imem[i] = 9'h000;
    m_reset();
    apply_reset();

    // Directed program: plain words, JMP 3, BRZ not-taken/taken, stalls, HALT.
    imem[0] = 9'h001; imem[1] = 9'h002; imem[2] = 9'h003; imem[3] = 9'h183;
    imem[4] = 9'h0AA; imem[5] = 9'h0AB;
    imem[9'h040] = 9'h143; imem[9'h041] = 9'h143;
    imem[9'h042] = 9'h1FF; imem[9'h043] = 9'h183;
    step(1'b1, 1'b0, 1'b1, 5'd3, 9'h040);      // IR empty: LUT write honoured
    for (int i = 0; i < 20; i++) begin dir_st[i] = 1'b0; dir_cd[i] = 1'b0; end
    dir_cd[7] = 1'b1; dir_st[8] = 1'b1; dir_st[10] = 1'b1; dir_st[11] = 1'b1;
    for (int i = 14; i < 20; i++) begin dir_st[i] = i[0]; dir_cd[i] = 1'b1; end
    for (int i = 0; i < 20; i++)
      step(dir_st[i], dir_cd[i], (i == 2), 5'd3, 9'h077);  // write at i=2 must be ignored
    chk("halted.done", Done, 1);
    chk("halted.lut3", m_lut[3], 9'h040);
    apply_reset();

    // Randomized rounds against the model, with an asynchronous reset during a flush.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 512; i++) imem[i] = rand_word();
      if (r % 2 == 0)
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b1, 5'(i), 9'($urandom));
      mid_reset_done = 1'b0;
      for (int k = 0; k < 150; k++) begin
        step($urandom_range(3) == 0, 1'($urandom), $urandom_range(7) == 0,
             5'($urandom), 9'($urandom));
        if (!mid_reset_done && m_mode == 1 && k > 20) begin
          mid_reset_done = 1'b1;
          #2 Reset = 1'b0;
          #1 check_reset_values("mid_flush_rst");
          @(negedge CLK);
          Reset = 1'b1;
          m_reset();
        end
      end
      apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
